// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
//   Groups the instruction-memory request/response signals, the decode-side
//   valid/ready handshake, and the redirect inputs of the fetch queue.
//
//   Signals:
//     IMemReq     fetch -> mem     one-cycle request pulse
//     IMemAddr    fetch -> mem     request address (valid with IMemReq)
//     IMemRdata   mem   -> fetch   returned instruction word
//     IMemValid   mem   -> fetch   response strobe
//     InstrValid  fetch -> decode  head entry available
//     InstrReady  decode-> fetch   decode consumes head entry
//     Instr       fetch -> decode  head instruction word
//     PCD         fetch -> decode  PC of head instruction
//     Redirect    exec  -> fetch   flush and restart at RedirectPC
//     RedirectPC  exec  -> fetch   new fetch address
//     InstrFault  fetch -> decode  head entry is a misaligned-fetch fault
//                                  (only with FETCHQ_MISALIGN_CHECK_EN)
//
//   Modports: master = fetch queue side, slave = memory/decode/exec side.
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  IMemReq;
  logic [DATA_WIDTH-1:0] IMemAddr;
  logic [DATA_WIDTH-1:0] IMemRdata;
  logic                  IMemValid;
  logic                  InstrValid;
  logic                  InstrReady;
  logic [DATA_WIDTH-1:0] Instr;
  logic [DATA_WIDTH-1:0] PCD;
  logic                  Redirect;
  logic [DATA_WIDTH-1:0] RedirectPC;
`ifdef FETCHQ_MISALIGN_CHECK_EN
  logic                  InstrFault;

  modport master (
    output IMemReq, IMemAddr, InstrValid, Instr, PCD, InstrFault,
    input  IMemRdata, IMemValid, InstrReady, Redirect, RedirectPC
  );
  modport slave (
    input  IMemReq, IMemAddr, InstrValid, Instr, PCD, InstrFault,
    output IMemRdata, IMemValid, InstrReady, Redirect, RedirectPC
  );
`else
  modport master (
    output IMemReq, IMemAddr, InstrValid, Instr, PCD,
    input  IMemRdata, IMemValid, InstrReady, Redirect, RedirectPC
  );
  modport slave (
    input  IMemReq, IMemAddr, InstrValid, Instr, PCD,
    output IMemRdata, IMemValid, InstrReady, Redirect, RedirectPC
  );
`endif
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch stage: generates the fetch PC, issues single-word
//   requests to instruction memory (at most one outstanding), buffers the
//   returned words with their PCs in a DEPTH-entry FIFO and presents the head
//   entry to decode with first-word fall-through under valid/ready.
//   A redirect flushes the queue, restarts fetch at RedirectPC and discards
//   any response still in flight.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    fetch_queue_if.master (memory, decode and redirect signals)
//
//   Optional build macro FETCHQ_MISALIGN_CHECK_EN:
//     a misaligned PCF pushes a single fault entry instead of a memory
//     request, drives InstrFault for that entry and halts fetch until the
//     next redirect. Without it, PCF[1:0] is ignored.
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pcf;
  logic [DATA_WIDTH-1:0] r_req_pc;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [DATA_WIDTH-1:0] r_word [DEPTH];
  logic [DATA_WIDTH-1:0] r_pc   [DEPTH];

  logic                  w_space;
  logic                  w_nonempty;
  logic                  w_fetch_ok;
  logic                  w_issue;
  logic                  w_fault_push;
  logic                  w_rsp_push;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_push_word;
  logic [DATA_WIDTH-1:0] w_push_pc;

  assign w_space    = (r_count < CW'(DEPTH));
  assign w_nonempty = (r_count != '0);

`ifdef FETCHQ_MISALIGN_CHECK_EN
  logic r_halt;
  logic r_fault [DEPTH];
  logic w_misalign;

  assign w_misalign   = (r_pcf[1:0] != 2'b00);
  assign w_fetch_ok   = (r_state == IDLE) && w_space && !bus.Redirect && !r_halt;
  // A misaligned PC never reaches memory; its fault entry is pushed directly.
  assign w_issue      = rst_n && w_fetch_ok && !w_misalign;
  assign w_fault_push = w_fetch_ok && w_misalign;
  assign bus.InstrFault = w_nonempty && r_fault[r_head];
`else
  assign w_fetch_ok   = (r_state == IDLE) && w_space && !bus.Redirect;
  // rst_n gating keeps the request low while reset is held.
  assign w_issue      = rst_n && w_fetch_ok;
  assign w_fault_push = 1'b0;
`endif

  // The count<DEPTH issue condition reserves a slot for every response.
  assign w_rsp_push  = (r_state == WAIT) && bus.IMemValid && !bus.Redirect;
  assign w_push      = w_rsp_push || w_fault_push;
  assign w_valid     = w_nonempty && !bus.Redirect;
  assign w_pop       = w_valid && bus.InstrReady;
  assign w_push_word = w_fault_push ? '0    : bus.IMemRdata;
  assign w_push_pc   = w_fault_push ? r_pcf : r_req_pc;

  assign bus.IMemReq    = w_issue;
  assign bus.IMemAddr   = r_pcf;
  assign bus.InstrValid = w_valid;
  // Gating on occupancy gives zero outputs after reset without resetting storage.
  assign bus.Instr      = w_nonempty ? r_word[r_head] : '0;
  assign bus.PCD        = w_nonempty ? r_pc[r_head]   : '0;

  // Queue storage and request PC: data only, no reset.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_req_pc <= r_pcf;
    end
    if (w_push) begin
      r_word[r_tail] <= w_push_word;
      r_pc[r_tail]   <= w_push_pc;
`ifdef FETCHQ_MISALIGN_CHECK_EN
      r_fault[r_tail] <= w_fault_push;
`endif
    end
  end

  // Control: PC, pointers, occupancy and request FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pcf   <= RESET_PC;
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
`ifdef FETCHQ_MISALIGN_CHECK_EN
      r_halt  <= 1'b0;
`endif
    end else begin
      if (bus.Redirect) begin
        r_pcf   <= bus.RedirectPC;
        r_count <= '0;
        r_head  <= '0;
        r_tail  <= '0;
`ifdef FETCHQ_MISALIGN_CHECK_EN
        r_halt  <= 1'b0;
`endif
      end else begin
        if (w_issue) begin
          r_pcf <= r_pcf + DATA_WIDTH'(4);
        end
        if (w_push) begin
          r_tail <= r_tail + PW'(1);
        end
        if (w_pop) begin
          r_head <= r_head + PW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
`ifdef FETCHQ_MISALIGN_CHECK_EN
        if (w_fault_push) begin
          r_halt <= 1'b1;
        end
`endif
      end

      case (r_state)
        IDLE: begin
          // A stray IMemValid here is ignored.
          if (w_issue) r_state <= WAIT;
        end
        WAIT: begin
          if (bus.IMemValid)     r_state <= IDLE;
          else if (bus.Redirect) r_state <= DROP;
        end
        DROP: begin
          if (bus.IMemValid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Directed bench for fetch_queue. A memory model answers each request a
//   programmable number of cycles later with data = addr ^ 32'hDEAD_0000.
//   Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  logic clk;
  logic rst_n;

  fetch_queue_if #(.DATA_WIDTH(32)) bus ();

  fetch_queue #(
    .DATA_WIDTH (32),
    .DEPTH      (4),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  int          mem_lat;
  int          req_count;
  int          req_base;

  // Memory model: samples the request at the rising edge, answers later.
  initial begin : mem_model
    int          cnt;
    logic        req_seen;
    logic [31:0] req_addr;
    logic [31:0] pend_addr;
    cnt       = 0;
    req_count = 0;
    pend_addr = '0;
    bus.IMemValid = 1'b0;
    bus.IMemRdata = '0;
    forever begin
      @(posedge clk);
      req_seen = bus.IMemReq;
      req_addr = bus.IMemAddr;
      #1;
      bus.IMemValid = 1'b0;
      if (cnt != 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          bus.IMemValid = 1'b1;
          bus.IMemRdata = pend_addr ^ 32'hDEAD_0000;
        end
      end
      if (req_seen) begin
        req_count = req_count + 1;
        pend_addr = req_addr;
        if (mem_lat <= 1) begin
          bus.IMemValid = 1'b1;
          bus.IMemRdata = req_addr ^ 32'hDEAD_0000;
        end else begin
          cnt = mem_lat - 1;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    bus.Redirect   = rd;
    bus.RedirectPC = rpc;
    bus.InstrReady = rdy;
    #1;
  endtask

  // Holds reset for 3 cycles, then releases it; the release cycle is C0.
  task automatic begin_test(input int lat, input logic rdy, input logic rd,
                            input logic [31:0] rpc);
    @(negedge clk);
    rst_n          = 1'b0;
    bus.Redirect   = 1'b0;
    bus.InstrReady = rdy;
    mem_lat        = lat;
    repeat (3) @(negedge clk);
    rst_n          = 1'b1;
    bus.Redirect   = rd;
    bus.RedirectPC = rpc;
    bus.InstrReady = rdy;
    req_base       = req_count;
    #1;
  endtask

  initial begin : main
    n_checks       = 0;
    n_fail         = 0;
    mem_lat        = 1;
    req_base       = 0;
    rst_n          = 1'b0;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = '0;
    bus.InstrReady = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   {31'd0, bus.IMemReq},    32'd0);
    check("rst_valid", {31'd0, bus.InstrValid}, 32'd0);
    check("rst_instr", bus.Instr,               32'h0);
    check("rst_pcd",   bus.PCD,                 32'h0);

    // Streaming with 1-cycle memory, decode always ready
    begin_test(1, 1'b1, 1'b0, 32'h0);
    check("t1_req_c0",  {31'd0, bus.IMemReq}, 32'd1);
    check("t1_addr_c0", bus.IMemAddr,         32'h0);
    step(1'b0, 32'h0, 1'b1);
    check("t1_req_c1",  {31'd0, bus.IMemReq},    32'd0);
    check("t1_vld_c1",  {31'd0, bus.InstrValid}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("t1_vld_c2",   {31'd0, bus.InstrValid}, 32'd1);
    check("t1_instr_c2", bus.Instr,               32'hDEAD_0000);
    check("t1_pcd_c2",   bus.PCD,                 32'h0);
    check("t1_addr_c2",  bus.IMemAddr,            32'h4);
    check("t1_req_c2",   {31'd0, bus.IMemReq},    32'd1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("t1_pcd_c4",  bus.PCD,      32'h4);
    check("t1_addr_c4", bus.IMemAddr, 32'h8);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("t1_pcd_c6",   bus.PCD,   32'h8);
    check("t1_instr_c6", bus.Instr, 32'hDEAD_0008);

    // Fill to DEPTH with decode stalled
    begin_test(1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0);
    check("t2_req_full",  {31'd0, bus.IMemReq},    32'd0);
    check("t2_vld_full",  {31'd0, bus.InstrValid}, 32'd1);
    check("t2_pcd_full",  bus.PCD,                 32'h0);
    check("t2_nreq_c8",   req_count - req_base,    32'd4);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("t2_req_c10",   {31'd0, bus.IMemReq},    32'd0);
    check("t2_nreq_c10",  req_count - req_base,    32'd4);
    check("t2_pcd_hold",  bus.PCD,                 32'h0);
    step(1'b0, 32'h0, 1'b1);
    check("t2_pcd_pop",   bus.PCD,                 32'h0);
    step(1'b0, 32'h0, 1'b0);
    check("t2_pcd_next",  bus.PCD,                 32'h4);
    check("t2_req_next",  {31'd0, bus.IMemReq},    32'd1);
    check("t2_addr_next", bus.IMemAddr,            32'h10);

    // Redirect while a 3-cycle request is outstanding
    begin_test(3, 1'b1, 1'b1, 32'h20);
    check("t3_req_c0",  {31'd0, bus.IMemReq}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("t3_req_c1",  {31'd0, bus.IMemReq}, 32'd1);
    check("t3_addr_c1", bus.IMemAddr,         32'h20);
    step(1'b1, 32'h100, 1'b1);
    check("t3_req_c2",  {31'd0, bus.IMemReq}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("t3_req_c3",  {31'd0, bus.IMemReq},    32'd0);
    check("t3_vld_c3",  {31'd0, bus.InstrValid}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("t3_req_c4",  {31'd0, bus.IMemReq},    32'd0);
    check("t3_vld_c4",  {31'd0, bus.InstrValid}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("t3_vld_c5",  {31'd0, bus.InstrValid}, 32'd0);
    check("t3_req_c5",  {31'd0, bus.IMemReq},    32'd1);
    check("t3_addr_c5", bus.IMemAddr,            32'h100);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("t3_vld_c7",  {31'd0, bus.InstrValid}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("t3_vld_c8",  {31'd0, bus.InstrValid}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("t3_vld_c9",   {31'd0, bus.InstrValid}, 32'd1);
    check("t3_pcd_c9",   bus.PCD,                 32'h100);
    check("t3_instr_c9", bus.Instr,               32'hDEAD_0100);

    // Redirect coinciding with a response, two entries queued
    begin_test(1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
    check("t4_addr_c4", bus.IMemAddr,            32'h8);
    check("t4_pcd_c4",  bus.PCD,                 32'h0);
    step(1'b1, 32'h40, 1'b1);
    check("t4_vld_c5",  {31'd0, bus.InstrValid}, 32'd0);
    check("t4_req_c5",  {31'd0, bus.IMemReq},    32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("t4_vld_c6",  {31'd0, bus.InstrValid}, 32'd0);
    check("t4_req_c6",  {31'd0, bus.IMemReq},    32'd1);
    check("t4_addr_c6", bus.IMemAddr,            32'h40);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("t4_vld_c8",  {31'd0, bus.InstrValid}, 32'd1);
    check("t4_pcd_c8",  bus.PCD,                 32'h40);

    // PC wrap at the top of the address space
    begin_test(1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check("t5_req_c0",  {31'd0, bus.IMemReq}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("t5_addr_c1", bus.IMemAddr,         32'hFFFF_FFFC);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("t5_pcd_c3",  bus.PCD,              32'hFFFF_FFFC);
    check("t5_req_c3",  {31'd0, bus.IMemReq}, 32'd1);
    check("t5_addr_c3", bus.IMemAddr,         32'h0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("t5_pcd_c5",  bus.PCD,              32'h0);

`ifdef FETCHQ_MISALIGN_CHECK_EN
    // Misaligned redirect produces one fault entry and halts fetch
    begin_test(1, 1'b0, 1'b1, 32'h102);
    step(1'b0, 32'h0, 1'b0);
    check("t6_req_c1",   {31'd0, bus.IMemReq},    32'd0);
    step(1'b0, 32'h0, 1'b0);
    check("t6_vld_c2",   {31'd0, bus.InstrValid}, 32'd1);
    check("t6_pcd_c2",   bus.PCD,                 32'h102);
    check("t6_instr_c2", bus.Instr,               32'h0);
    check("t6_fault_c2", {31'd0, bus.InstrFault}, 32'd1);
    check("t6_req_c2",   {31'd0, bus.IMemReq},    32'd0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    check("t6_vld_c4",   {31'd0, bus.InstrValid}, 32'd0);
    check("t6_req_c4",   {31'd0, bus.IMemReq},    32'd0);
    step(1'b1, 32'h200, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("t6_req_c6",   {31'd0, bus.IMemReq},    32'd1);
    check("t6_addr_c6",  bus.IMemAddr,            32'h200);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("t6_vld_c8",   {31'd0, bus.InstrValid}, 32'd1);
    check("t6_pcd_c8",   bus.PCD,                 32'h200);
    check("t6_fault_c8", {31'd0, bus.InstrFault}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
